// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct encodings, 3-bit ALU
// opcodes, the ID-stage FSM state type and the control bundle carried
// from ID into EX.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU opcodes understood by EX
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} id_state_t;

  // Control bundle as registered into ID/EX
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src_imm;
    logic       illegal;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder.
//   instr      : fetched instruction
//   ctrl       : control bundle (illegal set for anything outside the set)
//   uses_rs/rt : instruction reads rs / rt (feeds load-use hazard check)
//   write_addr : destination register, 0 when nothing is written
module id_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic [4:0]  write_addr
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  always_comb begin
    ctrl       = '0;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    write_addr = 5'd0;
    // The all-zero word is the canonical NOP: valid, no side effects.
    if (instr != 32'd0) begin
      case (op)
        OP_RTYPE: begin
          ctrl.reg_write = 1'b1;
          uses_rs        = 1'b1;
          uses_rt        = 1'b1;
          write_addr     = instr[15:11];
          case (fn)
            FN_ADD:  ctrl.alu_op = ALU_ADD;
            FN_SUB:  ctrl.alu_op = ALU_SUB;
            FN_AND:  ctrl.alu_op = ALU_AND;
            FN_OR:   ctrl.alu_op = ALU_OR;
            FN_SLT:  ctrl.alu_op = ALU_SLT;
            default: begin
              ctrl       = '0;
              ctrl.illegal = 1'b1;
              uses_rs    = 1'b0;
              uses_rt    = 1'b0;
              write_addr = 5'd0;
            end
          endcase
        end
        OP_ADDI: begin
          ctrl.alu_op      = ALU_ADD;
          ctrl.alu_src_imm = 1'b1;
          ctrl.reg_write   = 1'b1;
          uses_rs          = 1'b1;
          write_addr       = instr[20:16];
        end
        OP_LW: begin
          ctrl.alu_op      = ALU_ADD;
          ctrl.alu_src_imm = 1'b1;
          ctrl.mem_read    = 1'b1;
          ctrl.mem_to_reg  = 1'b1;
          ctrl.reg_write   = 1'b1;
          uses_rs          = 1'b1;
          write_addr       = instr[20:16];
        end
        OP_SW: begin
          ctrl.alu_op      = ALU_ADD;
          ctrl.alu_src_imm = 1'b1;
          ctrl.mem_write   = 1'b1;
          uses_rs          = 1'b1;
          uses_rt          = 1'b1;
        end
        OP_BEQ: begin
          ctrl.alu_op = ALU_SUB;
          ctrl.branch = 1'b1;
          uses_rs     = 1'b1;
          uses_rt     = 1'b1;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: drives register-file read addresses,
// decodes the IF/ID instruction, detects load-use hazards (one-cycle
// bubble + fetch stall), honours EX flushes and registers everything
// into ID/EX.
//   clock, reset_n          : clock, async active-low reset
//   ifid_*                  : instruction, PC+4 and valid from IF/ID
//   rf_read_addr_s/t        : combinational rs/rt read addresses
//   rf_out_a/b              : register-file data (falling-edge read)
//   ex_mem_read/write_addr  : load-in-EX info for hazard detection
//   flush                   : branch taken in EX, kill ID
//   stall_if                : hold PC and IF/ID this cycle
//   idex_*                  : ID/EX pipeline register
//   bubble_count            : saturating count of load-use bubbles
module id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ifid_valid,
  input  logic [31:0]       ifid_instr,
  input  logic [DATA_W-1:0] ifid_pc_plus4,
  output logic [4:0]        rf_read_addr_s,
  output logic [4:0]        rf_read_addr_t,
  input  logic [DATA_W-1:0] rf_out_a,
  input  logic [DATA_W-1:0] rf_out_b,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_write_addr,
  input  logic              flush,
  output logic              stall_if,
  output logic              idex_valid,
  output logic              idex_reg_write,
  output logic              idex_mem_read,
  output logic              idex_mem_write,
  output logic              idex_mem_to_reg,
  output logic              idex_branch,
  output logic              idex_alu_src_imm,
  output logic              idex_illegal,
  output logic [2:0]        idex_alu_op,
  output logic [DATA_W-1:0] idex_pc_plus4,
  output logic [DATA_W-1:0] idex_op_a,
  output logic [DATA_W-1:0] idex_op_b,
  output logic [DATA_W-1:0] idex_imm,
  output logic [4:0]        idex_rs,
  output logic [4:0]        idex_rt,
  output logic [4:0]        idex_write_addr,
  output logic [CNT_W-1:0]  bubble_count
);

  id_state_t         state;
  ctrl_t             dec_ctrl;
  ctrl_t             ctrl_q;
  logic              dec_uses_rs;
  logic              dec_uses_rt;
  logic [4:0]        dec_wa;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic              haz;
  logic              load_bubble;
  logic [DATA_W-1:0] imm_ext;

  assign rs             = ifid_instr[25:21];
  assign rt             = ifid_instr[20:16];
  assign rf_read_addr_s = rs;
  assign rf_read_addr_t = rt;
  assign imm_ext        = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};

  id_decode u_dec (
    .instr      (ifid_instr),
    .ctrl       (dec_ctrl),
    .uses_rs    (dec_uses_rs),
    .uses_rt    (dec_uses_rt),
    .write_addr (dec_wa)
  );

  // $0 is never a real dependency, so a load into $0 cannot stall.
  assign haz = ifid_valid & ex_mem_read & (ex_write_addr != 5'd0) &
               ((dec_uses_rs & (ex_write_addr == rs)) |
                (dec_uses_rt & (ex_write_addr == rt)));

  // In HOLD the bubble already sits in EX, so the hazard is stale.
  // Gating with reset_n keeps the stall low while reset is asserted.
  assign stall_if    = reset_n & (state == RUN) & haz & ~flush;
  assign load_bubble = flush | ~ifid_valid | stall_if;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RUN;
      ctrl_q          <= '0;
      idex_valid      <= 1'b0;
      idex_pc_plus4   <= '0;
      idex_op_a       <= '0;
      idex_op_b       <= '0;
      idex_imm        <= '0;
      idex_rs         <= '0;
      idex_rt         <= '0;
      idex_write_addr <= '0;
      bubble_count    <= '0;
    end else begin
      // flush forces RUN; a stall always lasts exactly one cycle
      state <= stall_if ? HOLD : RUN;

      if (load_bubble) begin
        ctrl_q          <= '0;
        idex_valid      <= 1'b0;
        idex_pc_plus4   <= '0;
        idex_op_a       <= '0;
        idex_op_b       <= '0;
        idex_imm        <= '0;
        idex_rs         <= '0;
        idex_rt         <= '0;
        idex_write_addr <= '0;
      end else begin
        ctrl_q          <= dec_ctrl;
        idex_valid      <= 1'b1;
        idex_pc_plus4   <= ifid_pc_plus4;
        idex_op_a       <= rf_out_a;
        idex_op_b       <= rf_out_b;
        idex_imm        <= imm_ext;
        idex_rs         <= rs;
        idex_rt         <= rt;
        idex_write_addr <= dec_wa;
      end

      if (stall_if && (bubble_count != {CNT_W{1'b1}}))
        bubble_count <= bubble_count + 1'b1;
    end
  end

  assign idex_reg_write   = ctrl_q.reg_write;
  assign idex_mem_read    = ctrl_q.mem_read;
  assign idex_mem_write   = ctrl_q.mem_write;
  assign idex_mem_to_reg  = ctrl_q.mem_to_reg;
  assign idex_branch      = ctrl_q.branch;
  assign idex_alu_src_imm = ctrl_q.alu_src_imm;
  assign idex_illegal     = ctrl_q.illegal;
  assign idex_alu_op      = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage. The driver applies one set of inputs per
// cycle, steps a reference model and queues the expected post-edge state;
// the monitor pops and compares after every rising edge.
module tb_id_stage;

  localparam int CW = 8;  // narrow counter so saturation is reachable

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc_plus4, rf_out_a, rf_out_b;
  logic [4:0]  rf_read_addr_s, rf_read_addr_t;
  logic        ex_mem_read, flush, stall_if;
  logic [4:0]  ex_write_addr;
  logic        idex_valid, idex_reg_write, idex_mem_read, idex_mem_write;
  logic        idex_mem_to_reg, idex_branch, idex_alu_src_imm, idex_illegal;
  logic [2:0]  idex_alu_op;
  logic [31:0] idex_pc_plus4, idex_op_a, idex_op_b, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_write_addr;
  logic [CW-1:0] bubble_count;

  id_stage #(.DATA_W(32), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .rf_read_addr_s(rf_read_addr_s), .rf_read_addr_t(rf_read_addr_t),
    .rf_out_a(rf_out_a), .rf_out_b(rf_out_b), .ex_mem_read(ex_mem_read),
    .ex_write_addr(ex_write_addr), .flush(flush), .stall_if(stall_if),
    .idex_valid(idex_valid), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
    .idex_mem_to_reg(idex_mem_to_reg), .idex_branch(idex_branch),
    .idex_alu_src_imm(idex_alu_src_imm), .idex_illegal(idex_illegal),
    .idex_alu_op(idex_alu_op), .idex_pc_plus4(idex_pc_plus4),
    .idex_op_a(idex_op_a), .idex_op_b(idex_op_b), .idex_imm(idex_imm),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_write_addr(idex_write_addr),
    .bubble_count(bubble_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit stall; bit [9:0] ra;
    bit valid, rw, mr, mw, m2r, br, si, ill; bit [2:0] alu;
    bit [31:0] pc, a, b, imm; bit [4:0] rs, rt, wa; bit [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    bit rw, mr, mw, m2r, br, si, ill; bit [2:0] alu;
    bit urs, urt; bit [4:0] wa;
  } dec_t;

  exp_t q[$];
  bit   m_hold;
  int   m_cnt;
  int   n_chk, n_fail;

  // Instruction-set table as read from the ISA description.
  function automatic dec_t ref_decode(input bit [31:0] ins);
    dec_t d = '{default: 0};
    bit [5:0] op = ins[31:26];
    bit [5:0] fn = ins[5:0];
    if (ins == 32'd0) return d;
    if (op == 6'h00) begin
      if (fn == 6'h20) d.alu = 3'b010;
      else if (fn == 6'h22) d.alu = 3'b110;
      else if (fn == 6'h24) d.alu = 3'b000;
      else if (fn == 6'h25) d.alu = 3'b001;
      else if (fn == 6'h2A) d.alu = 3'b111;
      else begin d.ill = 1; return d; end
      d.rw = 1; d.wa = ins[15:11]; d.urs = 1; d.urt = 1;
    end else if (op == 6'h08) begin
      d.alu = 3'b010; d.si = 1; d.rw = 1; d.wa = ins[20:16]; d.urs = 1;
    end else if (op == 6'h23) begin
      d.alu = 3'b010; d.si = 1; d.mr = 1; d.m2r = 1; d.rw = 1;
      d.wa = ins[20:16]; d.urs = 1;
    end else if (op == 6'h2B) begin
      d.alu = 3'b010; d.si = 1; d.mw = 1; d.urs = 1; d.urt = 1;
    end else if (op == 6'h04) begin
      d.alu = 3'b110; d.br = 1; d.urs = 1; d.urt = 1;
    end else d.ill = 1;
    return d;
  endfunction

  task automatic step(input bit rst, input bit v, input bit [31:0] ins,
                      input bit [31:0] pc, input bit [31:0] a, input bit [31:0] b,
                      input bit exmr, input bit [4:0] exwa, input bit fl);
    exp_t e = '{default: 0};
    dec_t d;
    bit haz, st;
    @(negedge clock);
    reset_n = rst; ifid_valid = v; ifid_instr = ins; ifid_pc_plus4 = pc;
    rf_out_a = a; rf_out_b = b; ex_mem_read = exmr; ex_write_addr = exwa;
    flush = fl;
    e.ra = {ins[25:21], ins[20:16]};
    if (!rst) begin
      m_hold = 0; m_cnt = 0;
    end else begin
      d   = ref_decode(ins);
      haz = v && exmr && exwa != 0 &&
            ((d.urs && exwa == ins[25:21]) || (d.urt && exwa == ins[20:16]));
      st  = !m_hold && haz && !fl;
      if (st && m_cnt < (1 << CW) - 1) m_cnt++;
      m_hold  = st;
      e.stall = st;
      e.cnt   = m_cnt[CW-1:0];
      if (v && !fl && !st) begin
        e.valid = 1; e.rw = d.rw; e.mr = d.mr; e.mw = d.mw; e.m2r = d.m2r;
        e.br = d.br; e.si = d.si; e.ill = d.ill; e.alu = d.alu;
        e.pc = pc; e.a = a; e.b = b; e.imm = {{16{ins[15]}}, ins[15:0]};
        e.rs = ins[25:21]; e.rt = ins[20:16]; e.wa = d.rw ? d.wa : 5'd0;
      end
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  bit       s_stall;
  bit [9:0] s_ra;
  exp_t     me;
  always @(posedge clock) begin
    s_stall = stall_if;
    s_ra    = {rf_read_addr_s, rf_read_addr_t};
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("stall_if", s_stall, me.stall);
      chk("rf_read_addr", s_ra, me.ra);
      chk("ctrl", {idex_valid, idex_reg_write, idex_mem_read, idex_mem_write,
                   idex_mem_to_reg, idex_branch, idex_alu_src_imm, idex_illegal,
                   idex_alu_op},
                  {me.valid, me.rw, me.mr, me.mw, me.m2r, me.br, me.si, me.ill, me.alu});
      chk("data", {idex_pc_plus4, idex_op_a, idex_op_b, idex_imm},
                  {me.pc, me.a, me.b, me.imm});
      chk("regs", {idex_rs, idex_rt, idex_write_addr}, {me.rs, me.rt, me.wa});
      chk("bubble_count", bubble_count, me.cnt);
    end
  end

  function automatic bit [31:0] rnd_instr();
    bit [4:0]  rs = 5'($urandom_range(0, 7));
    bit [4:0]  rt = 5'($urandom_range(0, 7));
    bit [4:0]  rd = 5'($urandom_range(0, 31));
    bit [15:0] im = 16'($urandom);
    case ($urandom_range(0, 10))
      0: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      2: return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      3: return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4: return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      5: return {6'h08, rs, rt, im};
      6: return {6'h23, rs, rt, im};
      7: return {6'h2B, rs, rt, im};
      8: return {6'h04, rs, rt, im};
      9: return 32'($urandom);
      default: return 32'd0;
    endcase
  endfunction

  localparam bit [31:0] ADD312 = 32'h00221820;  // add $3,$1,$2
  localparam bit [31:0] SUB425 = 32'h00452022;  // sub $4,$2,$5

  initial begin
    n_chk = 0; n_fail = 0; m_hold = 0; m_cnt = 0;
    reset_n = 0; ifid_valid = 0; ifid_instr = 0; ifid_pc_plus4 = 0;
    rf_out_a = 0; rf_out_b = 0; ex_mem_read = 0; ex_write_addr = 0; flush = 0;

    // reset with random inputs (hazard-shaped so stall_if would fire)
    for (int i = 0; i < 3; i++)
      step(0, 1, SUB425, $urandom, $urandom, $urandom, 1, 2, 0);

    // add $3,$1,$2 with operands 5 / 7
    step(1, 1, ADD312, 32'h104, 5, 7, 0, 0, 0);
    // load-use: stall one cycle, then HOLD ignores the stale hazard
    step(1, 1, SUB425, 32'h108, 9, 11, 1, 2, 0);
    step(1, 1, SUB425, 32'h108, 9, 11, 1, 2, 0);
    // same hazard with flush: bubble, no stall, no count; then a stall again
    step(1, 1, SUB425, 32'h10C, 1, 2, 1, 2, 1);
    step(1, 1, SUB425, 32'h10C, 1, 2, 1, 2, 0);
    step(1, 1, SUB425, 32'h10C, 1, 2, 0, 0, 0);
    // lw into $0 never stalls
    step(1, 1, 32'h00001820, 32'h110, 3, 4, 1, 0, 0);
    // addi $7,$0,-1
    step(1, 1, 32'h2007FFFF, 32'h114, 0, 0, 0, 0, 0);
    // illegal opcode 0x3F, then NOP
    step(1, 1, 32'hFC000000, 32'h118, 6, 6, 0, 0, 0);
    step(1, 1, 32'h00000000, 32'h11C, 6, 6, 0, 0, 0);
    // invalid slot with hazard shape: bubble, no stall
    step(1, 0, SUB425, 32'h120, 1, 1, 1, 2, 0);
    // reset in HOLD returns to RUN with nothing pending
    step(1, 1, SUB425, 32'h124, 1, 1, 1, 2, 0);
    step(0, 1, SUB425, 32'h124, 1, 1, 1, 2, 0);
    step(1, 1, SUB425, 32'h124, 1, 1, 1, 2, 0);
    step(1, 1, SUB425, 32'h124, 1, 1, 1, 2, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0, rnd_instr(),
           $urandom, $urandom, $urandom, $urandom_range(0, 2) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);

    // continuous hazard: a stall every other cycle until the counter saturates
    for (int i = 0; i < 2 * ((1 << CW) + 20); i++)
      step(1, 1, ADD312, 32'h200, 1, 2, 1, 1, 0);

    step(1, 0, 32'd0, 0, 0, 0, 0, 0, 0);
    // drain: queue must be empty within a bounded number of edges
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clock);
    #2;
    chk("scoreboard_drain", 128'(q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
